// File: rtl/tanh_inverse_search_pkg.sv
// Shared activation formats, tanh ROM geometry and inverse-search FSM encoding.
package tanh_inverse_search_pkg;

    localparam int Q35_FRAC   = 5;
    localparam int Q35_W      = 3 + Q35_FRAC;
    localparam int Q07_FRAC   = 7;
    localparam int Q07_W      = 1 + Q07_FRAC;

    localparam int ROM_DEPTH  = 256;
    localparam int IDX_W      = $clog2(ROM_DEPTH);
    localparam int ROM_OFFSET = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/tanh_inverse_search_rom.sv
// Combinational tanh ROM: Q3.5 code (offset index) in, saturated Q0.7 tanh out.
module tanh_q35_q07_rom
    import tanh_inverse_search_pkg::*;
(
    input  logic [IDX_W-1:0]        idx,
    output logic signed [Q07_W-1:0] t
);

    logic signed [IDX_W:0] c;
    logic [IDX_W-1:0]      a;
    logic [Q07_W-1:0]      mag;

    // tanh is odd, so only |c| is tabulated; the tail saturates to 127 on the
    // positive side but reaches -128 on the negative side from |c| = 100.
    always_comb begin
        c   = $signed({1'b0, idx}) - $signed((IDX_W+1)'(ROM_OFFSET));
        a   = c[IDX_W] ? IDX_W'(-c) : c[IDX_W-1:0];
        mag = 8'd0;
        case (a)
            8'd0:  mag = 8'd0;    8'd1:  mag = 8'd4;    8'd2:  mag = 8'd8;
            8'd3:  mag = 8'd12;   8'd4:  mag = 8'd16;   8'd5:  mag = 8'd20;
            8'd6:  mag = 8'd24;   8'd7:  mag = 8'd28;   8'd8:  mag = 8'd31;
            8'd9:  mag = 8'd35;   8'd10: mag = 8'd39;   8'd11: mag = 8'd42;
            8'd12: mag = 8'd46;   8'd13: mag = 8'd49;   8'd14: mag = 8'd53;
            8'd15: mag = 8'd56;   8'd16: mag = 8'd59;   8'd17: mag = 8'd62;
            8'd18: mag = 8'd65;   8'd19: mag = 8'd68;   8'd20: mag = 8'd71;
            8'd21: mag = 8'd74;   8'd22: mag = 8'd76;   8'd23: mag = 8'd79;
            8'd24: mag = 8'd81;   8'd25: mag = 8'd84;   8'd26: mag = 8'd86;
            8'd27: mag = 8'd88;   8'd28: mag = 8'd90;   8'd29: mag = 8'd92;
            8'd30: mag = 8'd94;   8'd31: mag = 8'd96;   8'd32: mag = 8'd97;
            8'd33: mag = 8'd99;   8'd34: mag = 8'd101;  8'd35: mag = 8'd102;
            8'd36: mag = 8'd104;  8'd37: mag = 8'd105;  8'd38: mag = 8'd106;
            8'd39: mag = 8'd107;  8'd40: mag = 8'd109;  8'd41: mag = 8'd110;
            8'd42: mag = 8'd111;  8'd43: mag = 8'd112;
            8'd44, 8'd45:                             mag = 8'd113;
            8'd46: mag = 8'd114;  8'd47: mag = 8'd115;  8'd48: mag = 8'd116;
            8'd49, 8'd50:                             mag = 8'd117;
            8'd51, 8'd52:                             mag = 8'd118;
            8'd53:                                    mag = 8'd119;
            8'd54, 8'd55, 8'd56:                      mag = 8'd120;
            8'd57, 8'd58:                             mag = 8'd121;
            8'd59, 8'd60, 8'd61:                      mag = 8'd122;
            8'd62, 8'd63, 8'd64:                      mag = 8'd123;
            8'd65, 8'd66, 8'd67, 8'd68:               mag = 8'd124;
            8'd69, 8'd70, 8'd71, 8'd72, 8'd73:        mag = 8'd125;
            8'd74, 8'd75, 8'd76, 8'd77, 8'd78,
            8'd79, 8'd80, 8'd81, 8'd82:               mag = 8'd126;
            default: mag = (c[IDX_W] && a >= 8'd100) ? 8'd128 : 8'd127;
        endcase
        t = c[IDX_W] ? $signed(8'd0 - mag) : $signed(mag);
    end

endmodule

// File: rtl/tanh_inverse_search.sv
// Sequential tanh inverse: lower-bound binary search of a Q0.7 activation over the tanh ROM.
module tanh_inverse_search
    import tanh_inverse_search_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] y_in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] x_out,
    output logic         out_valid,
    input  logic         out_ready,
    output state_t       state_dbg
);

    // Handshake: a transfer happens on any rising edge where valid and ready
    // are both high; valid never waits on ready, and ready/valid are registered.
    localparam int STEPS = W;
    localparam int CNT_W = $clog2(STEPS);

    state_t                  state;
    logic signed [W-1:0]     y_q;
    logic [IDX_W-1:0]        lo, hi, mid, lo_nxt, hi_nxt;
    logic [IDX_W:0]          sum;
    logic [CNT_W-1:0]        cnt;
    logic signed [Q07_W-1:0] t_mid;

    assign state_dbg = state;
    assign sum       = {1'b0, lo} + {1'b0, hi};
    assign mid       = sum[IDX_W:1];

    tanh_q35_q07_rom u_rom (
        .idx (mid),
        .t   (t_mid)
    );

    // Keep hi on a candidate with T >= y so lo converges on the lower bound.
    always_comb begin
        lo_nxt = lo;
        hi_nxt = hi;
        if (t_mid >= y_q) hi_nxt = mid;
        else              lo_nxt = mid + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            x_out     <= '0;
            y_q       <= '0;
            lo        <= '0;
            hi        <= '1;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        y_q      <= y_in;
                        lo       <= '0;
                        hi       <= '1;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= SEARCH;
                    end
                end
                SEARCH: begin
                    lo  <= lo_nxt;
                    hi  <= hi_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(STEPS - 1)) begin
                        x_out     <= W'(lo_nxt - IDX_W'(ROM_OFFSET));
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tanh_inverse_search.sv
// Directed and swept checks of the tanh inverse search against a real-valued tanh model.
module tb_tanh_inverse_search;
    import tanh_inverse_search_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] y_in;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] x_out;
    logic       out_valid;
    logic       out_ready;
    state_t     state_dbg;

    int total  = 0;
    int passes = 0;
    int fails  = 0;

    logic [7:0] exp_q[$];
    int         t_ref[256];

    logic [7:0] dir_y[10]   = '{8'h00, 8'h7F, 8'h80, 8'h81, 8'h05, 8'h04, 8'h7E, 8'h82, 8'h1F, 8'h20};
    logic [7:0] dir_exp[10] = '{8'h00, 8'h53, 8'h80, 8'h9D, 8'h02, 8'h01, 8'h4A, 8'hAE, 8'h08, 8'h09};

    always #5 clk = ~clk;

    tanh_inverse_search dut (
        .clk       (clk),
        .reset     (reset),
        .y_in      (y_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_out     (x_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_dbg (state_dbg)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic int tanh_code(input int c);
        real r;
        real v;
        int  iv;
        r  = 128.0 * $tanh(real'(c) / 32.0);
        v  = (r >= 0.0) ? $floor(r + 0.5) : -$floor(-r + 0.5);
        iv = $rtoi(v);
        if (iv > 127)  iv = 127;
        if (iv < -128) iv = -128;
        return iv;
    endfunction

    function automatic logic [7:0] lower_bound(input int y);
        for (int c = -128; c <= 127; c++)
            if (t_ref[c + 128] >= y) return 8'(c);
        return 8'h7F;
    endfunction

    task automatic run_req(input logic [7:0] y, input logic [7:0] expx, input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin step(); n++; end
        check($sformatf("%s ready", tag), {31'd0, in_ready}, 32'd1);
        y_in = y;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        y_in = 8'($urandom_range(0, 255));
        n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        check($sformatf("%s latency", tag), 32'(n), 32'd8);
        check($sformatf("%s x_out", tag), {24'd0, x_out}, {24'd0, expx});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check($sformatf("%s release", tag), {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        int n;
        int next_y;
        int got;
        int cyc;
        int last;

        for (int i = 0; i < 256; i++) t_ref[i] = tanh_code(i - 128);

        // reset state
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; y_in = 8'h00;
        step();
        step();
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset x_out", {24'd0, x_out}, 32'd0);
        check("reset state", {30'd0, state_dbg}, {30'd0, IDLE});
        reset = 1'b0;
        step();

        // directed vectors with hand-computed results
        for (int i = 0; i < 10; i++)
            run_req(dir_y[i], dir_exp[i], $sformatf("dir y=0x%02h", dir_y[i]));

        // back-pressure in DONE: y=100 -> 34 (T(33)=99 < 100 <= T(34)=101)
        y_in = 8'd100; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        check("bp latency", 32'(n), 32'd8);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; y_in = 8'h80; out_ready = 1'b0;
            step();
            check("bp x_out", {24'd0, x_out}, 32'h22);
            check("bp out_valid", {31'd0, out_valid}, 32'd1);
            check("bp in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp release ready/valid", {30'd0, in_ready, out_valid}, 32'd2);
        check("bp x_out held in idle", {24'd0, x_out}, 32'h22);
        step();
        check("bp no stray accept", {30'd0, state_dbg}, {30'd0, IDLE});

        // reset during SEARCH aborts the request
        y_in = 8'h7F; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        check("abort in search", {30'd0, state_dbg}, {30'd0, SEARCH});
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort state", {30'd0, state_dbg}, {30'd0, IDLE});
        check("abort out_valid", {31'd0, out_valid}, 32'd0);
        check("abort x_out", {24'd0, x_out}, 32'd0);
        check("abort in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("abort stays idle", {31'd0, out_valid}, 32'd0);
        run_req(8'h00, 8'h00, "post-abort y=0");

        // exhaustive back-to-back sweep against the model
        in_valid = 1'b1; out_ready = 1'b1;
        next_y = -128; got = 0; cyc = 0; last = -1;
        while (got < 256 && cyc < 3000) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("sweep spurious out_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    check($sformatf("sweep x_out #%0d", got), {24'd0, x_out}, {24'd0, exp_q.pop_front()});
                    if (last >= 0) check("sweep period", 32'(cyc - last), 32'd10);
                    last = cyc;
                    got++;
                end
            end
            if (in_ready) begin
                if (next_y <= 127) begin
                    y_in = 8'(next_y);
                    exp_q.push_back(lower_bound(next_y));
                    next_y++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            step();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("sweep results received", 32'(got), 32'd256);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
